cic_integrator_mc_pipe: RTL and testbench

//  Multichannel, multi-stage CIC integrator section for the DDC datapath, synchronous to CLK.

---
 rtl/cic_integrator_mc_pipe_if.sv | 24 ++
 rtl/cic_integrator_mc_pipe.sv | 119 +++++++++++
 tb/tb_cic_integrator_mc_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_integrator_mc_pipe_if.sv
// Sample bus for the multichannel CIC integrator.
// The producer drives in_*; the integrator drives out_* and err_ch.
interface cic_integrator_mc_pipe_if #(
  parameter int DATA_W = 37,
  parameter int CH_W   = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_ch;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              err_ch;

  modport master (
    output in_valid, in_data, in_ch,
    input  out_valid, out_data, out_ch, err_ch
  );

  modport slave (
    input  in_valid, in_data, in_ch,
    output out_valid, out_data, out_ch, err_ch
  );
endinterface

// File: rtl/cic_integrator_mc_pipe.sv
// Multichannel, multi-stage CIC integrator section.
// Time-interleaved samples tagged with a channel index run through NUM_STAGES
// cascaded integrators, each keeping one accumulator per channel. cfg_stage_en
// selects per stage whether it integrates or just passes data through, so the
// latency is always NUM_STAGES cycles. Adds wrap modulo 2**DATA_W on purpose.
// Optional feature macro: CIC_INT_CHCLR_EN adds ch_clr/ch_clr_idx, a
// per-channel accumulator clear that wins over a same-cycle update.
module cic_integrator_mc_pipe #(
  parameter int DATA_W     = 37,
  parameter int NUM_CH     = 16,
  parameter int CH_W       = 4,
  parameter int NUM_STAGES = 5
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NUM_STAGES-1:0] cfg_stage_en,
  input  logic                  sync_clr,
`ifdef CIC_INT_CHCLR_EN
  input  logic                  ch_clr,
  input  logic [CH_W-1:0]       ch_clr_idx,
`endif
  cic_integrator_mc_pipe_if.slave bus
);

  logic                  in_range;
  logic                  err_ch_reg;
  logic [NUM_CH-1:0]     clr_mask;
  logic [NUM_STAGES-1:0] stage_valid;
  logic [DATA_W-1:0]     stage_data [NUM_STAGES];
  logic [CH_W-1:0]       stage_ch   [NUM_STAGES];

  // Out-of-range channels never enter the pipeline.
  assign in_range = (32'(bus.in_ch) < 32'(NUM_CH));

  // One-hot set of channels whose accumulators are cleared this cycle.
  always_comb begin
    clr_mask = '0;
`ifdef CIC_INT_CHCLR_EN
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_clr && (32'(ch_clr_idx) == 32'(c))) clr_mask[c] = 1'b1;
    end
`endif
  end

  // Flag a dropped sample one cycle after it was presented.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) err_ch_reg <= 1'b0;
    else       err_ch_reg <= bus.in_valid & ~in_range;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic              vin;
      logic [DATA_W-1:0] din;
      logic [CH_W-1:0]   cin;
      logic [DATA_W-1:0] acc [NUM_CH];
      logic [DATA_W-1:0] sum;
      logic              valid_reg;
      logic [DATA_W-1:0] data_reg;
      logic [CH_W-1:0]   ch_reg;

      if (gi == 0) begin : g_head
        assign vin = bus.in_valid & in_range;
        assign din = bus.in_data;
        assign cin = bus.in_ch;
      end else begin : g_link
        assign vin = stage_valid[gi-1];
        assign din = stage_data[gi-1];
        assign cin = stage_ch[gi-1];
      end

      // Single-cycle read-modify-write: the next sample of the same channel
      // sees this update, so back-to-back samples need no forwarding.
      assign sum = acc[cin] + din;

      // Accumulator bank: global clear, per-channel clear, then integrate.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else if (sync_clr) begin
          for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (clr_mask[c])
              acc[c] <= '0;
            else if (vin && cfg_stage_en[gi] && (32'(cin) == 32'(c)))
              acc[c] <= sum;
          end
        end
      end

      // Stage output register; a disabled stage is a plain delay.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          ch_reg    <= '0;
        end else begin
          valid_reg <= vin & ~sync_clr;
          if (vin) begin
            data_reg <= cfg_stage_en[gi] ? sum : din;
            ch_reg   <= cin;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_data[gi]  = data_reg;
      assign stage_ch[gi]    = ch_reg;
    end
  endgenerate

  assign bus.out_valid = stage_valid[NUM_STAGES-1];
  assign bus.out_data  = stage_data[NUM_STAGES-1];
  assign bus.out_ch    = stage_ch[NUM_STAGES-1];
  assign bus.err_ch    = err_ch_reg;

endmodule

// File: tb/tb_cic_integrator_mc_pipe.sv
// Bench for cic_integrator_mc_pipe: directed CIC cases, randomized streams
// against a cascade-of-accumulators reference model, channel-range errors,
// sync_clr and asynchronous reset behaviour.
module tb_cic_integrator_mc_pipe;
  localparam int DW  = 37;
  localparam int NCH = 12;
  localparam int CW  = 4;
  localparam int NS  = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ch;
    logic [31:0]   cyc;
  } smp_t;

  logic          CLK      = 1'b0;
  logic          nRST     = 1'b0;
  logic          sync_clr = 1'b0;
  logic [NS-1:0] cfg      = '0;
`ifdef CIC_INT_CHCLR_EN
  logic          ch_clr     = 1'b0;
  logic [CW-1:0] ch_clr_idx = '0;
`endif

  cic_integrator_mc_pipe_if #(.DATA_W(DW), .CH_W(CW)) bus ();

  cic_integrator_mc_pipe #(
    .DATA_W(DW), .NUM_CH(NCH), .CH_W(CW), .NUM_STAGES(NS)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .cfg_stage_en (cfg),
    .sync_clr     (sync_clr),
`ifdef CIC_INT_CHCLR_EN
    .ch_clr       (ch_clr),
    .ch_clr_idx   (ch_clr_idx),
`endif
    .bus          (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  smp_t          exp_q[$];
  smp_t          obs_q[$];
  logic [31:0]   err_exp_q[$];
  logic [31:0]   err_obs_q[$];
  logic [DW-1:0] m_acc [NS][NCH];
  int            n_checks = 0;
  int            n_errs   = 0;

  // Collect every output sample and error pulse with its cycle stamp.
  always @(negedge CLK) begin
    smp_t s;
    if (bus.out_valid === 1'b1) begin
      s.data = bus.out_data;
      s.ch   = bus.out_ch;
      s.cyc  = cycle;
      obs_q.push_back(s);
    end
    if (bus.err_ch === 1'b1) err_obs_q.push_back(cycle);
  end

  function automatic void model_clear();
    for (int k = 0; k < NS; k++)
      for (int c = 0; c < NCH; c++) m_acc[k][c] = '0;
  endfunction

  // Reference: a cascade of per-channel running sums, evaluated at once.
  function automatic logic [DW-1:0] model_run(logic [DW-1:0] x, int c);
    logic [DW-1:0] v = x;
    for (int k = 0; k < NS; k++) begin
      if (cfg[k]) begin
        m_acc[k][c] = m_acc[k][c] + v;
        v = m_acc[k][c];
      end
    end
    return v;
  endfunction

  // Present one cycle of input and record what the model expects from it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic clr);
    smp_t e;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ch    = c;
    sync_clr     = clr;
    if (clr) begin
      model_clear();
      while (exp_q.size() > 0 && exp_q[$].cyc >= cycle + 1) void'(exp_q.pop_back());
    end else if (v && int'(c) < NCH) begin
      e.data = model_run(d, int'(c));
      e.ch   = c;
      e.cyc  = cycle + 5;
      exp_q.push_back(e);
    end else if (v) begin
      err_exp_q.push_back(cycle + 1);
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
    sync_clr     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errs++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== '0) begin n_errs++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
    n_checks++;
    if (bus.out_ch !== '0) begin n_errs++; $display("FAIL reset_out_ch got=%h want=0", bus.out_ch); end
    n_checks++;
    if (bus.err_ch !== 1'b0) begin n_errs++; $display("FAIL reset_err_ch got=%b want=0", bus.err_ch); end
    #2 nRST = 1'b1;
    @(negedge CLK);
    $display("test_reset done: checks=%0d errors=%0d", n_checks, n_errs);
  endtask

  task automatic test_directed();
    logic [DW-1:0] gold[$];
    logic [DW-1:0] big;
    logic [DW-1:0] g;
    smp_t          e, o;
    big = {1'b0, {36{1'b1}}};
    for (int p = 1; p <= 4; p++) begin
      gold.delete();
      cfg = (p == 2) ? 5'b11111 : 5'b00001;
      step(1'b0, '0, '0, 1'b1);
      idle(6);
      case (p)
        1: begin
          step(1'b1, 37'd1, 4'd0, 1'b0);
          gold.push_back(37'd1);
          for (int i = 0; i < 7; i++) begin step(1'b1, '0, 4'd0, 1'b0); gold.push_back(37'd1); end
        end
        2: begin
          for (int i = 0; i < 5; i++) step(1'b1, 37'd1, 4'd0, 1'b0);
          gold.push_back(37'd1); gold.push_back(37'd6); gold.push_back(37'd21);
          gold.push_back(37'd56); gold.push_back(37'd126);
        end
        3: begin
          for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin step(1'b1, 37'd1, 4'd0, 1'b0); gold.push_back(37'(i / 2 + 1)); end
            else begin step(1'b1, 37'd2, 4'd3, 1'b0); gold.push_back(37'(2 * (i / 2 + 1))); end
          end
        end
        default: begin
          step(1'b1, big, 4'd5, 1'b0);
          step(1'b1, 37'd1, 4'd5, 1'b0);
          gold.push_back(big);
          gold.push_back({1'b1, 36'd0});
        end
      endcase
      idle(7);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = gold.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin
          n_errs++;
          $display("FAIL directed%0d_missing got=none want=data %0d ch %0d at cycle %0d", p, $signed(e.data), e.ch, e.cyc);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin
            n_errs++;
            $display("FAIL directed%0d_model got=data %0d ch %0d cyc %0d want=data %0d ch %0d cyc %0d",
                     p, $signed(o.data), o.ch, o.cyc, $signed(e.data), e.ch, e.cyc);
          end
          n_checks++;
          if (o.data !== g) begin
            n_errs++;
            $display("FAIL directed%0d_golden got=%0d want=%0d", p, $signed(o.data), $signed(g));
          end
          $display("directed%0d out ch=%0d data=%0d cyc=%0d", p, o.ch, $signed(o.data), o.cyc);
        end
      end
      n_checks++;
      if (obs_q.size() != 0) begin n_errs++; $display("FAIL directed%0d_extra got=%0d outputs want=0", p, obs_q.size()); obs_q.delete(); end
      n_checks++;
      if (err_obs_q.size() != 0) begin n_errs++; $display("FAIL directed%0d_err_ch got=%0d pulses want=0", p, err_obs_q.size()); err_obs_q.delete(); end
    end
  endtask

  task automatic test_back_to_back_random();
    smp_t        e, o;
    logic [63:0] t;
    logic [CW-1:0] ch;
    int          r;
    for (int round = 0; round < 3; round++) begin
      cfg = NS'($urandom_range(0, 31));
      step(1'b0, '0, '0, 1'b1);
      idle(6);
      for (int i = 0; i < 80; i++) begin
        t = {$urandom(), $urandom()};
        r = $urandom_range(0, 3);
        ch = (r == 0) ? 4'd0 : (r == 1) ? 4'd11 : CW'($urandom_range(0, 15));
        step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, t[DW-1:0], ch, 1'b0);
      end
      idle(7);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) begin
          n_errs++;
          $display("FAIL random%0d_missing got=none want=data %0d ch %0d at cycle %0d", round, $signed(e.data), e.ch, e.cyc);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin
            n_errs++;
            $display("FAIL random%0d_model got=data %0d ch %0d cyc %0d want=data %0d ch %0d cyc %0d",
                     round, $signed(o.data), o.ch, o.cyc, $signed(e.data), e.ch, e.cyc);
          end
        end
      end
      n_checks++;
      if (obs_q.size() != 0) begin n_errs++; $display("FAIL random%0d_extra got=%0d outputs want=0", round, obs_q.size()); obs_q.delete(); end
      n_checks++;
      if (err_obs_q != err_exp_q) begin
        n_errs++;
        $display("FAIL random%0d_err_ch got=%0d pulses want=%0d", round, err_obs_q.size(), err_exp_q.size());
      end
      $display("random round %0d cfg=%b err_pulses=%0d", round, cfg, err_exp_q.size());
      err_obs_q.delete();
      err_exp_q.delete();
    end
  endtask

  task automatic test_bad_ch();
    smp_t e, o;
    cfg = 5'b00001;
    step(1'b0, '0, '0, 1'b1);
    idle(6);
    step(1'b1, 37'd123, 4'd15, 1'b0);
    step(1'b1, 37'd7, 4'd12, 1'b0);
    step(1'b1, 37'd4, 4'd11, 1'b0);
    idle(7);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_errs++;
      $display("FAIL bad_ch_out_count got=%0d want=1", obs_q.size());
    end else begin
      e = exp_q[0];
      o = obs_q[0];
      n_checks++;
      if (o !== e) begin n_errs++; $display("FAIL bad_ch_ch11 got=data %0d ch %0d want=data %0d ch %0d", o.data, o.ch, e.data, e.ch); end
    end
    n_checks++;
    if (err_obs_q != err_exp_q) begin
      n_errs++;
      $display("FAIL bad_ch_err_pulses got=%0d pulses want=%0d", err_obs_q.size(), err_exp_q.size());
    end
    $display("bad_ch outputs=%0d err_pulses=%0d", obs_q.size(), err_obs_q.size());
    exp_q.delete(); obs_q.delete(); err_exp_q.delete(); err_obs_q.delete();
  endtask

  task automatic test_sync_clr();
    smp_t e, o;
    cfg = 5'b00001;
    step(1'b0, '0, '0, 1'b1);
    idle(6);
    for (int i = 0; i < 4; i++) step(1'b1, 37'd1, 4'd0, 1'b0);
    step(1'b1, 37'd7, 4'd0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errs++; $display("FAIL sync_clr_out_valid got=%b want=0", bus.out_valid); end
    step(1'b1, 37'd1, 4'd0, 1'b0);
    idle(7);
    n_checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_errs++;
      $display("FAIL sync_clr_count got=%0d outputs want=1", obs_q.size());
    end else begin
      e = exp_q[0];
      o = obs_q[0];
      n_checks++;
      if (o !== e || o.data !== 37'd1) begin
        n_errs++;
        $display("FAIL sync_clr_resume got=data %0d cyc %0d want=data 1 cyc %0d", o.data, o.cyc, e.cyc);
      end
    end
    $display("sync_clr resumed outputs=%0d", obs_q.size());
    exp_q.delete(); obs_q.delete(); err_exp_q.delete(); err_obs_q.delete();
  endtask

  task automatic test_nrst();
    smp_t o;
    cfg = 5'b00001;
    step(1'b0, '0, '0, 1'b1);
    idle(6);
    for (int i = 0; i < 7; i++) step(1'b1, 37'd5, 4'd2, 1'b0);
    #2 nRST = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 37'd9;
    bus.in_ch    = 4'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_ch !== '0 || bus.err_ch !== 1'b0) begin
        n_errs++;
        $display("FAIL nrst_low%0d got=valid %b data %0d ch %0d err %b want=all 0",
                 k, bus.out_valid, bus.out_data, bus.out_ch, bus.err_ch);
      end
      @(negedge CLK);
    end
    bus.in_valid = 1'b0;
    model_clear();
    exp_q.delete(); obs_q.delete(); err_exp_q.delete(); err_obs_q.delete();
    #2 nRST = 1'b1;
    @(negedge CLK);
    step(1'b1, 37'd1, 4'd0, 1'b0);
    idle(7);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_errs++;
      $display("FAIL nrst_resume_count got=%0d want=1", obs_q.size());
    end else begin
      o = obs_q[0];
      n_checks++;
      if (o !== exp_q[0] || o.data !== 37'd1) begin
        n_errs++;
        $display("FAIL nrst_resume got=data %0d ch %0d cyc %0d want=data 1 ch 0 cyc %0d", o.data, o.ch, o.cyc, exp_q[0].cyc);
      end
    end
    $display("nrst resumed outputs=%0d", obs_q.size());
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_ch    = '0;
    model_clear();
    test_reset();
    test_directed();
    test_back_to_back_random();
    test_bad_ch();
    test_sync_clr();
    test_nrst();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end
endmodule
